out_module: RTL and testbench

Output-side peripheral of the CPU I/O path, complementing the switch input module. It accepts a 32-bit word from the CPU datapath on a write strobe and converts its low 16 bits to decimal with a sequential shift-add-3 (double-dabble) engine. It then drives six active-low seven-segment digits with leading-zero blanking. A busy/done handshake lets the control unit stall or poll while a conversion is in progress.

---
 rtl/out_module.sv | 161 ++++++++++++++++
 tb/tb_out_module.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/out_module.sv
// CPU output peripheral: 16-bit binary to 5-digit BCD (double-dabble) driving six active-low 7-seg digits.
// Optional signed display enabled by defining OUT_SIGNED_EN.
module out_module (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        write_en,
    output logic        busy,
    output logic        done,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     bin_q, bin_d;
    logic [19:0]     bcd_q, bcd_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0][6:0] hex_q, hex_d;
    logic [4:0][6:0] hex_enc;
    logic [19:0]     adj;
    logic [4:0]      nz;
    logic [15:0]     operand;
    logic            unused_hi;

    assign unused_hi = ^data_in[31:16];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

`ifdef OUT_SIGNED_EN
    logic       sign_q, sign_d;
    logic [6:0] hex5_q, hex5_d;
    // Negating 0x8000 yields 0x8000 again, which is the correct 32768 magnitude.
    assign operand = data_in[15] ? (~data_in[15:0] + 16'd1) : data_in[15:0];
    assign hex5    = hex5_q;
`else
    assign operand = data_in[15:0];
    assign hex5    = 7'h7F;
`endif

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
    end

    // nz[i] is set when digit i or any digit above it is nonzero; zeros above the MSD blank.
    always_comb begin
        nz[4] = |bcd_q[19:16];
        nz[3] = nz[4] | (|bcd_q[15:12]);
        nz[2] = nz[3] | (|bcd_q[11:8]);
        nz[1] = nz[2] | (|bcd_q[7:4]);
        nz[0] = 1'b1;
        hex_enc = '1;
        for (int unsigned i = 0; i < 5; i++) begin
            if (nz[i]) hex_enc[i] = seg(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hex_d   = hex_q;
`ifdef OUT_SIGNED_EN
        sign_d  = sign_q;
        hex5_d  = hex5_q;
`endif
        case (state_q)
            IDLE: begin
                if (write_en) begin
                    bin_d   = operand;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
`ifdef OUT_SIGNED_EN
                    sign_d  = data_in[15];
`endif
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = UPDATE;
            end
            UPDATE: begin
                hex_d   = hex_enc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef OUT_SIGNED_EN
                hex5_d  = sign_q ? 7'h3F : 7'h7F;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {{4{7'h7F}}, 7'h40};
`ifdef OUT_SIGNED_EN
            sign_q  <= 1'b0;
            hex5_q  <= 7'h7F;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
`ifdef OUT_SIGNED_EN
            sign_q  <= sign_d;
            hex5_q  <= hex5_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];

endmodule

// File: tb/tb_out_module.sv
// Randomized self-checking bench for out_module against an arithmetic decimal/segment model.
// Honours OUT_SIGNED_EN in the model when the design is built with it.
module tb_out_module;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        write_en;
    logic        busy, done;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hx [6];
    logic [6:0]  exp_hex [6];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    out_module dut (
        .clk(clk), .reset(reset), .data_in(data_in), .write_en(write_en),
        .busy(busy), .done(done),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    assign hx[0] = hex0;
    assign hx[1] = hex1;
    assign hx[2] = hex2;
    assign hx[3] = hex3;
    assign hx[4] = hex4;
    assign hx[5] = hex5;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic set_reset_exp();
        exp_hex[0] = 7'h40;
        for (int i = 1; i < 6; i++) exp_hex[i] = 7'h7F;
    endtask

    // Expected display computed directly from the decimal value of the operand.
    task automatic model(input logic [31:0] d);
        int v;
        int pw;
        int msd;
        int dig [5];
        bit neg;
        v   = int'(d[15:0]);
        neg = 1'b0;
`ifdef OUT_SIGNED_EN
        if (d[15]) begin
            neg = 1'b1;
            v   = 65536 - v;
        end
`endif
        pw  = 1;
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            dig[i] = (v / pw) % 10;
            if (dig[i] != 0) msd = i;
            pw = pw * 10;
        end
        for (int i = 0; i < 5; i++) exp_hex[i] = (i > msd) ? 7'h7F : seg_of(dig[i]);
        exp_hex[5] = neg ? 7'h3F : 7'h7F;
    endtask

    task automatic check_hex(input string tag);
        for (int i = 0; i < 6; i++) check_eq($sformatf("%s.hex%0d", tag, i), {25'd0, hx[i]}, {25'd0, exp_hex[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion from the accepting edge (edge 0) through edge 17, plus edge 18 unless hold
    // keeps write_en high with nxt so that the caller's next conversion is accepted at edge 18.
    task automatic convert(input logic [31:0] d, input bit inject, input bit hold, input logic [31:0] nxt);
        string t;
        t = $sformatf("conv_%0h", d);
        data_in  = d;
        write_en = 1'b1;
        tick();
        check_eq({t, ".accept_busy"}, {31'd0, busy}, 32'd1);
        check_eq({t, ".accept_done"}, {31'd0, done}, 32'd0);
        write_en = hold;
        data_in  = hold ? nxt : $urandom;
        for (int e = 1; e <= 16; e++) begin
            if (inject && e == 5) begin
                write_en = 1'b1;
                data_in  = nxt;
            end
            tick();
            if (!hold) write_en = 1'b0;
            check_eq($sformatf("%s.busy_e%0d", t, e), {31'd0, busy}, 32'd1);
            check_eq($sformatf("%s.done_e%0d", t, e), {31'd0, done}, 32'd0);
            if (e == 8 || e == 16) check_hex($sformatf("%s.hold_e%0d", t, e));
        end
        model(d);
        tick();
        check_eq({t, ".done_e17"}, {31'd0, done}, 32'd1);
        check_eq({t, ".busy_e17"}, {31'd0, busy}, 32'd0);
        check_hex({t, ".result"});
        if (!hold) begin
            tick();
            check_eq({t, ".done_e18"}, {31'd0, done}, 32'd0);
            check_eq({t, ".busy_e18"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d, nxt;
        reset    = 1'b1;
        write_en = 1'b0;
        data_in  = '0;
        set_reset_exp();
        #2;
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        check_eq("rst.done", {31'd0, done}, 32'd0);
        check_hex("rst");
        tick();
        tick();
        reset = 1'b0;

        convert(32'h0000_0000, 1'b0, 1'b0, 32'h0);
        convert(32'h0000_04D2, 1'b0, 1'b0, 32'h0);
        convert(32'hABCD_FFFF, 1'b0, 1'b0, 32'h0);
        convert(32'h0000_0064, 1'b1, 1'b0, 32'h0000_0009);
        convert(32'h0000_8000, 1'b0, 1'b0, 32'h0);
        convert(32'h0000_FFFF, 1'b0, 1'b0, 32'h0);
        convert(32'h0000_000A, 1'b0, 1'b1, 32'h0000_270F);
        convert(32'h0000_270F, 1'b0, 1'b0, 32'h0);

        // Abort mid-conversion: outputs go to reset values at once, not at the next edge.
        data_in  = 32'h0000_1234;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        set_reset_exp();
        check_eq("abort.busy", {31'd0, busy}, 32'd0);
        check_eq("abort.done", {31'd0, done}, 32'd0);
        check_hex("abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq($sformatf("abort.nodone_%0d", i), {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        convert(32'h0000_1234, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            d   = $urandom;
            nxt = $urandom;
            if (i % 4 == 0) d = {$urandom, 16'h0} | $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) begin
                convert(d, 1'b0, 1'b1, nxt);
                convert(nxt, 1'b0, 1'b0, 32'h0);
            end else begin
                convert(d, 1'($urandom_range(0, 1)), 1'b0, nxt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
